// File: rtl/quick_spi_multi_if.sv
// Request/response and SPI pin bundle for quick_spi_multi.
// The slave modport is the SPI master block itself; the master modport is the fabric side.
interface quick_spi_multi_if #(
    parameter int MAX_DATA_LENGTH = 16,
    parameter int NUM_DEVICES     = 1,
    parameter int NUM_CS          = 4
);
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int NUM_W  = $clog2(MAX_DATA_LENGTH + 1);
    localparam int LANE_W = MAX_DATA_LENGTH * NUM_DEVICES;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        mode_i;
    logic [CS_W-1:0]   cs_sel_i;
    logic [NUM_W-1:0]  num_data_i;
    logic [LANE_W-1:0] data_i;
    logic [LANE_W-1:0] data_o;
    logic              data_valid_o;
    logic              sclk_o;
    logic [NUM_CS-1:0] cs_n_o;
    logic [NUM_DEVICES-1:0] sdata_i;
    logic [NUM_DEVICES-1:0] sdata_o;

    modport slave (
        input  req_valid_i, mode_i, cs_sel_i, num_data_i, data_i, sdata_i,
        output req_ready_o, data_o, data_valid_o, sclk_o, cs_n_o, sdata_o
    );

    modport master (
        output req_valid_i, mode_i, cs_sel_i, num_data_i, data_i, sdata_i,
        input  req_ready_o, data_o, data_valid_o, sclk_o, cs_n_o, sdata_o
    );
endinterface

// File: rtl/quick_spi_multi.sv
// Multi-lane SPI master: per-transfer CPOL/CPHA, decoded chip selects, shared SCLK.
// One request in flight; result words are strobed once at the end of each transfer.
module quick_spi_multi #(
    parameter int CLK_DIV           = 4,
    parameter int MAX_DATA_LENGTH   = 16,
    parameter int NUM_DEVICES       = 1,
    parameter int NUM_CS            = 4,
    parameter int CS_TO_SCLK_CLOCKS = 2,
    parameter int HOLDOFF_CLOCKS    = 9
) (
    input  logic clk_i,
    input  logic rst_ni,
    quick_spi_multi_if.slave spi
);
    localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int NUM_W    = $clog2(MAX_DATA_LENGTH + 1);
    localparam int LANE_W   = MAX_DATA_LENGTH * NUM_DEVICES;
    localparam int WAIT_A   = (CLK_DIV > CS_TO_SCLK_CLOCKS) ? CLK_DIV : CS_TO_SCLK_CLOCKS;
    localparam int WAIT_MAX = (WAIT_A > HOLDOFF_CLOCKS) ? WAIT_A : HOLDOFF_CLOCKS;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam int EDGE_W   = $clog2(2 * MAX_DATA_LENGTH + 1);

    typedef logic [MAX_DATA_LENGTH-1:0] word_t;
    typedef enum logic [2:0] {IDLE, PREP, SETUP, SHIFT, HOLDOFF} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [NUM_W-1:0]  n_q;
    logic [NUM_W-1:0]  n_in;
    logic              cpol, cpha;
    logic [CS_W-1:0]   cs_sel_q;
    logic              sclk;
    logic              data_valid;
    logic [NUM_CS-1:0] cs_n;
    logic [NUM_DEVICES-1:0] sdata;
    logic [LANE_W-1:0] data_q;
    word_t             tx_sr     [NUM_DEVICES];
    word_t             rx_sr     [NUM_DEVICES];
    word_t             load_word [NUM_DEVICES];

    logic accept, start, tick, finish, ready;
    logic edge_now, leading, last_trail, drive, sample;

    // A zero (or out-of-range) length request means a full-width transfer.
    function automatic logic [NUM_W-1:0] eff_len(input logic [NUM_W-1:0] num);
        if (num == '0 || int'(num) > MAX_DATA_LENGTH)
            return NUM_W'(MAX_DATA_LENGTH);
        return num;
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(sel) == i) v[i] = 1'b0;
        return v;
    endfunction

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        start   = 1'b0;
        tick    = 1'b0;
        finish  = 1'b0;
        ready   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (spi.req_valid_i) begin
                    accept  = 1'b1;
                    state_n = PREP;
                end
            end
            PREP: state_n = SETUP;
            SETUP: begin
                if (cnt == '0) begin
                    start   = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    if (edge_cnt != '0) begin
                        tick = 1'b1;
                    end else begin
                        finish  = 1'b1;
                        state_n = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (cnt == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // TX words are left-aligned so the next bit to send is always the MSB.
    always_comb begin
        n_in = eff_len(spi.num_data_i);
        for (int l = 0; l < NUM_DEVICES; l++)
            load_word[l] = spi.data_i[l*MAX_DATA_LENGTH +: MAX_DATA_LENGTH]
                           << (MAX_DATA_LENGTH - int'(n_in));
    end

    assign edge_now   = start | tick;
    assign leading    = (sclk == cpol);
    assign last_trail = (edge_cnt == EDGE_W'(1));
    assign drive      = leading ? cpha : (~cpha & ~last_trail);
    assign sample     = leading ^ cpha;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt        <= '0;
            edge_cnt   <= '0;
            n_q        <= '0;
            cpol       <= 1'b0;
            cpha       <= 1'b0;
            cs_sel_q   <= '0;
            sclk       <= 1'b0;
            cs_n       <= '1;
            data_valid <= 1'b0;
        end else begin
            data_valid <= finish;
            if (accept) begin
                cpol     <= spi.mode_i[1];
                cpha     <= spi.mode_i[0];
                cs_sel_q <= spi.cs_sel_i;
                n_q      <= n_in;
                sclk     <= spi.mode_i[1];
            end
            if (state == PREP) begin
                cs_n <= cs_decode(cs_sel_q);
                cnt  <= CNT_W'(CS_TO_SCLK_CLOCKS - 1);
            end else if (start) begin
                cnt      <= CNT_W'(CLK_DIV - 1);
                edge_cnt <= EDGE_W'(2 * int'(n_q) - 1);
            end else if (tick) begin
                cnt      <= CNT_W'(CLK_DIV - 1);
                edge_cnt <= edge_cnt - EDGE_W'(1);
            end else if (finish) begin
                cnt  <= CNT_W'(HOLDOFF_CLOCKS - 1);
                cs_n <= '1;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (edge_now) sclk <= ~sclk;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sdata  <= '0;
            data_q <= '0;
        end else begin
            for (int l = 0; l < NUM_DEVICES; l++) begin
                if (accept)
                    sdata[l] <= spi.mode_i[0] ? 1'b0 : load_word[l][MAX_DATA_LENGTH-1];
                else if (edge_now && drive)
                    sdata[l] <= tx_sr[l][MAX_DATA_LENGTH-1];
                else if (finish)
                    sdata[l] <= 1'b0;
                if (finish)
                    data_q[l*MAX_DATA_LENGTH +: MAX_DATA_LENGTH] <= rx_sr[l];
            end
        end
    end

    // With CPHA=0 the first bit is already on the pin, so the shifter starts one bit ahead.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < NUM_DEVICES; l++) begin
            if (accept) begin
                tx_sr[l] <= spi.mode_i[0] ? load_word[l] : (load_word[l] << 1);
                rx_sr[l] <= '0;
            end else if (edge_now) begin
                if (drive)  tx_sr[l] <= tx_sr[l] << 1;
                if (sample) rx_sr[l] <= (rx_sr[l] << 1) | word_t'(spi.sdata_i[l]);
            end
        end
    end

    assign spi.req_ready_o  = ready;
    assign spi.data_o       = data_q;
    assign spi.data_valid_o = data_valid;
    assign spi.sclk_o       = sclk;
    assign spi.cs_n_o       = cs_n;
    assign spi.sdata_o      = sdata;
endmodule

// File: tb/tb_quick_spi_multi.sv
// Bench for quick_spi_multi: directed table, random transfers against a bus-level slave model,
// plus back-to-back, mid-transfer reset and reset-state sequences.
module tb_quick_spi_multi;
    localparam int DIV  = 2;
    localparam int MAXL = 16;
    localparam int C2S  = 2;
    localparam int HOLD = 9;

    logic clk = 1'b0;
    logic rst_n;
    logic loopback;
    logic [1:0] slave_miso;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    quick_spi_multi_if #(.MAX_DATA_LENGTH(MAXL), .NUM_DEVICES(2), .NUM_CS(3)) ifc();

    assign ifc.sdata_i = loopback ? ifc.sdata_o : slave_miso;

    quick_spi_multi #(
        .CLK_DIV(DIV), .MAX_DATA_LENGTH(MAXL), .NUM_DEVICES(2), .NUM_CS(3),
        .CS_TO_SCLK_CLOCKS(C2S), .HOLDOFF_CLOCKS(HOLD)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .spi(ifc.slave)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  cs;
        logic [4:0]  num;
        logic [31:0] tx;
        logic [31:0] miso;
        logic        loop;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mask_lanes(input logic [31:0] w, input int n);
        logic [15:0] m;
        m = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
        return {w[31:16] & m, w[15:0] & m};
    endfunction

    function automatic logic bitof(input logic [15:0] w, input int idx);
        if (idx < 0 || idx > 15) return 1'b0;
        return w[idx];
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!ifc.req_ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_req", ifc.req_ready_o, 1);
    endtask

    // Drives one request, acts as the SPI slave on every lane, and checks the observed bus.
    task automatic run_xfer(input vec_t v);
        int n, i, lead, trail, vcount, cs_low, cs_bad, cs_fall;
        int first_lead, valid_i, ready_i, budget;
        logic cpol, cpha, prev_sclk, prev_high, done;
        logic [2:0] pat;
        logic [15:0] m0, m1, c0, c1;
        logic [31:0] cap;
        n = (v.num == 0) ? 16 : int'(v.num);
        cpol = v.mode[1];
        cpha = v.mode[0];
        m0 = v.miso[15:0];
        m1 = v.miso[31:16];
        pat = (v.cs < 3) ? ~(3'b001 << v.cs) : 3'b111;
        wait_ready();
        loopback = v.loop;
        ifc.mode_i = v.mode;
        ifc.cs_sel_i = v.cs;
        ifc.num_data_i = v.num;
        ifc.data_i = v.tx;
        slave_miso = cpha ? 2'b00 : {bitof(m1, n-1), bitof(m0, n-1)};
        ifc.req_valid_i = 1'b1;
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        ifc.mode_i = ~v.mode;
        ifc.cs_sel_i = 2'($urandom_range(0, 3));
        ifc.num_data_i = 5'($urandom_range(0, 16));
        ifc.data_i = $urandom;
        check("sclk_level_in_prep", ifc.sclk_o, cpol);
        lead = 0; trail = 0; vcount = 0; cs_low = 0; cs_bad = 0; cs_fall = 0;
        first_lead = -1; valid_i = -1; ready_i = -1;
        c0 = '0; c1 = '0; cap = '0;
        prev_sclk = ifc.sclk_o;
        prev_high = 1'b1;
        done = 1'b0;
        budget = 2 + C2S + 2 * MAXL * DIV + HOLD + 20;
        i = 1;
        while (!done && i <= budget) begin
            if (i >= 2 && ifc.sclk_o != prev_sclk) begin
                if (ifc.sclk_o != cpol) begin
                    lead++;
                    if (first_lead < 0) first_lead = i;
                    if (!cpha) begin
                        c0 = (c0 << 1) | 16'(ifc.sdata_o[0]);
                        c1 = (c1 << 1) | 16'(ifc.sdata_o[1]);
                    end else begin
                        slave_miso = {bitof(m1, n-lead), bitof(m0, n-lead)};
                    end
                end else begin
                    trail++;
                    if (cpha) begin
                        c0 = (c0 << 1) | 16'(ifc.sdata_o[0]);
                        c1 = (c1 << 1) | 16'(ifc.sdata_o[1]);
                    end else begin
                        slave_miso = {bitof(m1, n-1-trail), bitof(m0, n-1-trail)};
                    end
                end
            end
            prev_sclk = ifc.sclk_o;
            if (ifc.cs_n_o != 3'b111) cs_low++;
            if (ifc.cs_n_o != 3'b111 && ifc.cs_n_o != pat) cs_bad++;
            if (prev_high && ifc.cs_n_o != 3'b111) cs_fall++;
            prev_high = (ifc.cs_n_o == 3'b111);
            if (ifc.data_valid_o) begin
                vcount++;
                cap = ifc.data_o;
                valid_i = i;
            end
            if (vcount > 0 && ifc.req_ready_o) begin
                ready_i = i;
                done = 1'b1;
            end else begin
                @(negedge clk);
                i++;
            end
        end
        if (!done) check("xfer_timeout", 0, 1);
        check("leading_edges", lead, n);
        check("trailing_edges", trail, n);
        check("valid_pulses", vcount, 1);
        check("rx_data", cap, v.exp);
        check("mosi_bits", {c1, c0}, mask_lanes(v.tx, n));
        check("cs_low_cycles", cs_low, (v.cs < 3) ? (C2S + 2 * n * DIV) : 0);
        check("cs_wrong_line", cs_bad, 0);
        check("cs_windows", cs_fall, (v.cs < 3) ? 1 : 0);
        check("first_lead_time", first_lead, 2 + C2S);
        check("valid_time", valid_i, 2 + C2S + 2 * n * DIV);
        check("holdoff_len", ready_i - valid_i, HOLD);
        check("data_o_held", ifc.data_o, v.exp);
    endtask

    initial begin
        vec_t v;
        int n, k, windows, gap, changes;
        logic prev_high, flip;
        rst_n = 1'b0;
        loopback = 1'b1;
        slave_miso = '0;
        ifc.req_valid_i = 1'b0;
        ifc.mode_i = '0;
        ifc.cs_sel_i = '0;
        ifc.num_data_i = '0;
        ifc.data_i = '0;

        tbl[0] = '{2'd0, 2'd1, 5'd8,  32'h003C_00A5, 32'h0000_0000, 1'b1, 32'h003C_00A5};
        tbl[1] = '{2'd3, 2'd0, 5'd0,  32'h0001_F00F, 32'hABCD_1234, 1'b0, 32'hABCD_1234};
        tbl[2] = '{2'd1, 2'd2, 5'd1,  32'hFFFF_FFFF, 32'hFFFE_0001, 1'b0, 32'h0000_0001};
        tbl[3] = '{2'd2, 2'd1, 5'd5,  32'h0015_FFE3, 32'h0000_0000, 1'b1, 32'h0015_0003};
        tbl[4] = '{2'd0, 2'd3, 5'd4,  32'h1234_5678, 32'h0006_0009, 1'b0, 32'h0006_0009};
        tbl[5] = '{2'd1, 2'd0, 5'd12, 32'h0F0F_5A5A, 32'hF123_0ABC, 1'b0, 32'h0123_0ABC};

        repeat (3) @(negedge clk);
        check("rst_cs_n", ifc.cs_n_o, 3'b111);
        check("rst_sclk", ifc.sclk_o, 0);
        check("rst_sdata", ifc.sdata_o, 0);
        check("rst_data_o", ifc.data_o, 0);
        check("rst_valid", ifc.data_valid_o, 0);
        check("rst_ready", ifc.req_ready_o, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) run_xfer(tbl[t]);

        for (int r = 0; r < 30; r++) begin
            v.mode = 2'($urandom_range(0, 3));
            v.cs   = 2'($urandom_range(0, 3));
            v.num  = 5'($urandom_range(0, 16));
            v.tx   = $urandom;
            v.miso = $urandom;
            v.loop = 1'($urandom_range(0, 1));
            n = (v.num == 0) ? 16 : int'(v.num);
            v.exp  = mask_lanes(v.loop ? v.tx : v.miso, n);
            run_xfer(v);
        end

        // Back-to-back with req_valid held high and CPOL alternating.
        wait_ready();
        loopback = 1'b1;
        ifc.mode_i = 2'd0;
        ifc.cs_sel_i = 2'd0;
        ifc.num_data_i = 5'd4;
        ifc.data_i = 32'h0000_000A;
        ifc.req_valid_i = 1'b1;
        windows = 0; gap = 0; flip = 1'b0; prev_high = 1'b1;
        for (k = 0; k < 600 && !(windows == 4 && ifc.cs_n_o == 3'b111); k++) begin
            if (flip) begin
                ifc.mode_i = ifc.mode_i ^ 2'b10;
                flip = 1'b0;
            end
            if (ifc.req_ready_o) flip = 1'b1;
            if (prev_high && ifc.cs_n_o != 3'b111) begin
                if (windows > 0) check("b2b_gap_ge_holdoff", gap >= HOLD, 1);
                check("b2b_sclk_at_cs_fall", ifc.sclk_o, windows % 2);
                windows++;
            end
            if (!prev_high && ifc.cs_n_o == 3'b111) begin
                check("b2b_sclk_at_cs_rise", ifc.sclk_o, (windows - 1) % 2);
                gap = 0;
            end
            if (ifc.cs_n_o == 3'b111) gap++;
            prev_high = (ifc.cs_n_o == 3'b111);
            @(negedge clk);
        end
        ifc.req_valid_i = 1'b0;
        check("b2b_windows", windows, 4);

        // Reset in the middle of SHIFT.
        wait_ready();
        repeat (HOLD + 4) @(negedge clk);
        ifc.mode_i = 2'd2;
        ifc.cs_sel_i = 2'd0;
        ifc.num_data_i = 5'd0;
        ifc.data_i = 32'hFFFF_FFFF;
        ifc.req_valid_i = 1'b1;
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        @(negedge clk);
        changes = 0;
        prev_high = ifc.sclk_o;
        for (k = 0; k < 100 && changes < 3; k++) begin
            @(negedge clk);
            if (ifc.sclk_o != prev_high) changes++;
            prev_high = ifc.sclk_o;
        end
        check("midreset_reached_shift", changes, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_cs_n", ifc.cs_n_o, 3'b111);
        check("midreset_sclk", ifc.sclk_o, 0);
        check("midreset_ready", ifc.req_ready_o, 1);
        check("midreset_data_o", ifc.data_o, 0);
        rst_n = 1'b1;
        n = 0;
        for (k = 0; k < 80; k++) begin
            @(negedge clk);
            if (ifc.data_valid_o) n++;
        end
        check("midreset_no_valid", n, 0);
        check("midreset_idle_cs", ifc.cs_n_o, 3'b111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
